// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase sequencer: FSM state encoding and
// the phase-index width rule.
package phase_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width of a binary index that can address n phases.
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/phase_sequencer_dec.sv
// Binary-to-one-hot decoder with an enable.
// The output is all zero while en_i is low.
module dec #(
    parameter int in_cnt  = 2,
    parameter int out_cnt = 4
) (
    input  logic [in_cnt-1:0]  bin_i,
    input  logic               en_i,
    output logic [out_cnt-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            for (int k = 0; k < out_cnt; k++) begin
                if (bin_i == in_cnt'(k)) begin
                    onehot_o[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Steps a one-hot phase vector through len+1 phases, either once (with a done
// pulse) or repeatedly, with stall and abort control.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int N_PHASES = 4,
    localparam int CW      = $clog2(N_PHASES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                finish,
    input  logic                stall,
    input  logic [CW-1:0]       len,
    input  logic                loop_mode,
    output logic [N_PHASES-1:0] secv,
    output logic [CW-1:0]       phase_idx,
    output logic                busy,
    output logic                last,
    output logic                done
);

    localparam int IW = idx_width(N_PHASES);
    localparam logic [CW:0] MAX_LEN = (CW + 1)'(N_PHASES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] len_q, len_d;
    logic          loop_q, loop_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start && !finish) begin
                    state_d = RUN;
                    loop_d  = loop_mode;
                    // Non-power-of-two phase counts can receive an index past the end.
                    if ({1'b0, len} > MAX_LEN) begin
                        len_d = MAX_LEN[CW-1:0];
                    end else begin
                        len_d = len;
                    end
                end
            end
            RUN: begin
                if (finish) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (!stall) begin
                    if (idx_q < len_q) begin
                        idx_d = idx_q + 1'b1;
                    end else if (loop_q) begin
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy      = (state_q == RUN);
    assign last      = busy && (idx_q == len_q);
    assign done      = done_q;
    assign phase_idx = idx_q;

    dec #(
        .in_cnt (IW),
        .out_cnt(N_PHASES)
    ) u_dec (
        .bin_i   (idx_q),
        .en_i    (busy),
        .onehot_o(secv)
    );

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The module SHALL have parameter N_PHASES, default 4, the number of one-hot phase outputs (legal range 2..16).
REQ-002 The module SHALL have localparam CW, equal to $clog2(N_PHASES), the phase index width.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  requests a sequence; sampled only in IDLE.
REQ-006 Port finish  input  1  aborts the running sequence.
REQ-007 Port stall  input  1  holds the current phase for the cycle it is high.
REQ-008 Port len  input  CW  index of the last phase (active phases = len+1); latched at start.
REQ-009 Port loop_mode  input  1  selects behaviour after the last phase: 1 = wrap, 0 = one-shot; latched at start.
REQ-010 Port secv  output  N_PHASES  one-hot phase vector; all zero when idle.
REQ-011 Port phase_idx  output  CW  binary index of the current phase.
REQ-012 Port busy  output  1  high while in RUN.
REQ-013 Port last  output  1  high while phase_idx equals the latched len in RUN.
REQ-014 Port done  output  1  one-cycle pulse on one-shot completion.

Function
REQ-015 The block SHALL be a two-state FSM with states IDLE and RUN; all outputs SHALL be registered or decoded from registers.
REQ-016 Transition IDLE->RUN: start=1 and finish=0 at an edge.
    - Next cycle: phase_idx=0, secv=...0001, busy=1.
    - len and loop_mode latched at that edge.
REQ-017 If start and finish are both 1 in IDLE, finish SHALL dominate and the FSM SHALL stay in IDLE.
REQ-018 A latched len >= N_PHASES SHALL be clamped to N_PHASES-1.
REQ-019 In RUN with stall=0, finish=0 and phase_idx < len_q, phase_idx SHALL increment by 1 per cycle.
REQ-020 In RUN with stall=1 and finish=0, phase_idx, secv, last and the FSM state SHALL hold.
REQ-021 In RUN at phase_idx == len_q with stall=0, finish=0 and loop_mode_q=1, phase_idx SHALL wrap to 0; no done pulse.
REQ-022 In RUN at phase_idx == len_q with stall=0, finish=0 and loop_mode_q=0:
    - the FSM SHALL go to IDLE;
    - done SHALL pulse high for exactly the following cycle, coincident with busy=0 and secv=0.
REQ-023 finish=1 in RUN SHALL return the FSM to IDLE on the next edge regardless of stall, with no done pulse.
REQ-024 start asserted in RUN SHALL be ignored; len and loop_mode changes during RUN SHALL have no effect.
REQ-025 secv SHALL equal (1 << phase_idx) in RUN and SHALL be all zero in IDLE; it SHALL never have more than one bit set.
REQ-026 len_q = 0 SHALL give a one-phase sequence.
    - One-shot: secv=...0001 for one cycle, then done.
    - Loop: secv holds ...0001.

Reset
REQ-027 When rst=1 at an edge, the following SHALL be set, overriding start, finish and stall:
    - FSM=IDLE, phase_idx=0, secv=0;
    - busy=0, last=0, done=0;
    - len_q=0, loop_mode_q=0.
REQ-028 Reset asserted mid-sequence SHALL abort it with no done pulse; the first start after rst deasserts SHALL behave as REQ-016.

Structure
REQ-029 Package phase_seq_pkg SHALL hold:
    - the state enum (IDLE, RUN);
    - the width helper used to derive CW.
REQ-030 Binary-to-one-hot conversion of phase_idx SHALL be done by instantiating the existing dec sub-module, with in_cnt=CW and out_cnt=N_PHASES, gated by busy.

Verification (N_PHASES=4 unless stated)
REQ-031 Basic one-shot: len=3, loop_mode=0, start pulse.
    - secv = 0001, 0010, 0100, 1000 on successive cycles.
    - Next cycle: done=1, busy=0, secv=0000.
REQ-032 Stall: len=2, stall high for 2 cycles during phase 1 -> secv=0010 held for 3 cycles, then 0100, then done.
REQ-033 Loop with abort: len=1, loop_mode=1 -> secv alternates 0001/0010 with no done; finish while secv=0010 -> next cycle secv=0000, done=0.
REQ-034 Boundaries:
    - start and finish together in IDLE -> busy stays 0.
    - N_PHASES=8, len=7, one-shot -> 8 phases, then done.
REQ-035 Reset: rst during phase 2 of len=3 -> next cycle all outputs 0; a new start then yields secv=0001.
